load_store_unit: RTL and testbench

// - Data-memory access stage downstream of the control unit: consumes mem_write, load[2:0], store[1:0], ALU address, rs2 data.
// - Drives a req/ack data-memory port with byte enables; returns the sign/zero-extended load result to writeback.
// - Holds the core via stall until the access completes; one access in flight at a time.

---
 rtl/load_store_unit_pkg.sv | 51 +++++
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit_load_extend.sv | 46 ++++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// ============================================================================
//  load_store_unit_pkg
//  Load/store codes, FSM states and byte-lane helpers for the load/store unit.
//  Rev 1.0
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b011;
   localparam logic [2:0] LD_LHU = 3'b100;

   localparam logic [1:0] ST_SB  = 2'b00;
   localparam logic [1:0] ST_SH  = 2'b01;
   localparam logic [1:0] ST_SW  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } lsu_state_t;

   function automatic logic [3:0] store_be(input logic [1:0] code, input logic [1:0] off);
      logic [3:0] be;
      be = 4'b1111;
      case (code)
         ST_SB:   be = 4'b0001 << off;
         ST_SH:   be = 4'b0011 << {off[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicating the low byte/half onto every lane places it under whichever enable is set.
   function automatic logic [31:0] store_lanes(input logic [1:0] code, input logic [31:0] data);
      logic [31:0] lanes;
      lanes = data;
      case (code)
         ST_SB:   lanes = {4{data[7:0]}};
         ST_SH:   lanes = {2{data[15:0]}};
         default: lanes = data;
      endcase
      return lanes;
   endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// ============================================================================
//  load_store_unit_if
//  Data-memory req/ack port with byte enables; master = LSU, slave = memory.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface load_store_unit_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          dmem_req;
   logic          dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [3:0]    dmem_be;
   logic [DW-1:0] dmem_wdata;
   logic [DW-1:0] dmem_rdata;
   logic          dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
// ============================================================================
//  load_extend
//  Selects the addressed byte/half of a read word and sign/zero-extends it.
//  Rev 1.0
// ============================================================================
`default_nettype none

module load_extend
   import load_store_unit_pkg::*;
(
   input  wire logic [31:0] rdata,
   input  wire logic [2:0]  load,
   input  wire logic [1:0]  offset,
   output logic      [31:0] result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'h00;
      case (offset)
         2'd0:    w_byte = rdata[7:0];
         2'd1:    w_byte = rdata[15:8];
         2'd2:    w_byte = rdata[23:16];
         default: w_byte = rdata[31:24];
      endcase
   end

   assign w_half = offset[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      result = 32'h0000_0000;
      case (load)
         LD_LB:   result = {{24{w_byte[7]}}, w_byte};
         LD_LH:   result = {{16{w_half[15]}}, w_half};
         LD_LW:   result = rdata;
         LD_LBU:  result = {24'h000000, w_byte};
         LD_LHU:  result = {16'h0000, w_half};
         default: result = 32'h0000_0000;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
//  load_store_unit
//  Data-memory access stage: one req/ack access in flight, stalls the core
//  until done. Optional macro MISALIGN_TRAP_EN flags misaligned accesses.
//  Rev 1.0
// ============================================================================
`default_nettype none

module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          mem_read,
   input  wire logic          mem_write,
   input  wire logic [2:0]    load,
   input  wire logic [1:0]    store,
   input  wire logic [AW-1:0] addr,
   input  wire logic [DW-1:0] wdata,
   output logic               stall,
   output logic      [DW-1:0] rdata,
   output logic               misalign,
   load_store_unit_if.master  dmem
);

   lsu_state_t    state;
   lsu_state_t    state_nxt;

   logic          w_start;
   logic          w_is_store;
   logic          w_invalid;
   logic          w_misaligned;
   logic          w_skip;
   logic [31:0]   w_ext;

   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [3:0]    r_be;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rdata;
   logic [2:0]    r_load;
   logic [1:0]    r_off;

   // A store takes priority when both strobes are present.
   assign w_start    = mem_read | mem_write;
   assign w_is_store = mem_write;
   assign w_invalid  = w_is_store ? (store == 2'b11) : (load > LD_LHU);

`ifdef MISALIGN_TRAP_EN
   assign w_misaligned = w_is_store
      ? (((store == ST_SH) && addr[0]) || ((store == ST_SW) && (addr[1:0] != 2'b00)))
      : ((((load == LD_LH) || (load == LD_LHU)) && addr[0]) ||
         ((load == LD_LW) && (addr[1:0] != 2'b00)));
`else
   assign w_misaligned = 1'b0;
`endif

   assign w_skip = w_invalid | w_misaligned;

   load_extend u_load_extend (
      .rdata  (dmem.dmem_rdata),
      .load   (r_load),
      .offset (r_off),
      .result (w_ext)
   );

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      case (state)
         S_IDLE: begin
            if (w_start) begin
               stall     = 1'b1;
               state_nxt = w_skip ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            stall = 1'b1;
            if (dmem.dmem_ack) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_be    <= 4'b0000;
         r_wdata <= '0;
         r_rdata <= '0;
         r_load  <= 3'b000;
         r_off   <= 2'b00;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (w_start) begin
                  r_we    <= w_is_store;
                  r_addr  <= {addr[AW-1:2], 2'b00};
                  // Reads fetch the whole word; lane selection happens on return.
                  r_be    <= w_is_store ? store_be(store, addr[1:0]) : 4'b1111;
                  r_wdata <= w_is_store ? store_lanes(store, wdata) : '0;
                  r_load  <= load;
                  r_off   <= addr[1:0];
                  r_rdata <= '0;
               end
            end
            S_REQ: begin
               if (dmem.dmem_ack && !r_we) begin
                  r_rdata <= w_ext;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MISALIGN_TRAP_EN
   logic r_misalign;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_misalign <= 1'b0;
      end else if ((state == S_IDLE) && w_start) begin
         r_misalign <= w_misaligned;
      end else if (state == S_DONE) begin
         r_misalign <= 1'b0;
      end
   end

   assign misalign = r_misalign;
`else
   assign misalign = 1'b0;
`endif

   assign rdata           = r_rdata;
   assign dmem.dmem_req   = (state == S_REQ);
   assign dmem.dmem_we    = (state == S_REQ) && r_we;
   assign dmem.dmem_be    = (state == S_REQ) ? r_be : 4'b0000;
   assign dmem.dmem_addr  = r_addr;
   assign dmem.dmem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  tb_load_store_unit
//  Randomized scoreboard bench: byte-array reference memory model, random-latency responder.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  load;
   logic [1:0]  store;
   logic [31:0] addr, wdata;
   logic        stall, misalign;
   logic [31:0] rdata;

   load_store_unit_if #(.AW(32), .DW(32)) dmem ();

   load_store_unit #(.AW(32), .DW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .load      (load),
      .store     (store),
      .addr      (addr),
      .wdata     (wdata),
      .stall     (stall),
      .rdata     (rdata),
      .misalign  (misalign),
      .dmem      (dmem)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wmask;
      logic [31:0] wdat;
   } req_t;

   typedef struct {
      logic        chk_rdata;
      logic [31:0] rdata;
      logic        mis;
      logic        access;
      int          issue;
   } done_t;

   req_t        exp_req[$];
   done_t       exp_done[$];
   int          wait_q[$];

   logic [31:0] ref_mem[16];
   logic [31:0] sim_mem[16];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit resp_en = 1'b1;
   bit monitor_en = 1'b1;
   int forced_wait = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory responder: random wait states, applies writes by byte enable.
   initial begin
      int wait_rem = -1;
      dmem.dmem_ack   = 1'b0;
      dmem.dmem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (resp_en) begin
            if (dmem.dmem_req) begin
               if (wait_rem < 0) begin
                  wait_rem = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
                  wait_q.push_back(wait_rem);
               end
               if (wait_rem == 0) begin
                  dmem.dmem_ack   = 1'b1;
                  dmem.dmem_rdata = sim_mem[dmem.dmem_addr[5:2]];
                  if (dmem.dmem_we) begin
                     for (int b = 0; b < 4; b++)
                        if (dmem.dmem_be[b])
                           sim_mem[dmem.dmem_addr[5:2]][b*8 +: 8] = dmem.dmem_wdata[b*8 +: 8];
                  end
                  wait_rem = -1;
               end else begin
                  dmem.dmem_ack   = 1'b0;
                  dmem.dmem_rdata = $urandom;
                  wait_rem--;
               end
            end else begin
               dmem.dmem_ack   = 1'b0;
               dmem.dmem_rdata = $urandom;
            end
         end
      end
   end

   // Monitor: pops expectations as requests and completions appear.
   initial begin
      bit   prev_req = 1'b0;
      bit   prev_stall = 1'b0;
      bit   have_cur = 1'b0;
      req_t cur;
      forever begin
         @(negedge clk);
         if (monitor_en) begin
            if (dmem.dmem_req) begin
               if (!prev_req) begin
                  if (exp_req.size() == 0) begin
                     n_cmp++; n_bad++; have_cur = 1'b0;
                     $display("FAIL unexpected_req: got addr %h expected no request", dmem.dmem_addr);
                  end else begin
                     cur = exp_req.pop_front();
                     have_cur = 1'b1;
                  end
               end
               if (have_cur) begin
                  check("req_addr", dmem.dmem_addr, cur.addr);
                  check("req_we", {31'b0, dmem.dmem_we}, {31'b0, cur.we});
                  if (cur.we) begin
                     check("req_be", {28'b0, dmem.dmem_be}, {28'b0, cur.be});
                     check("req_wdata", dmem.dmem_wdata & cur.wmask, cur.wdat);
                  end
               end
            end
            if (prev_stall && !stall) begin
               if (exp_done.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_done: got completion expected none");
               end else begin
                  done_t d;
                  int    exp_lat;
                  d = exp_done.pop_front();
                  exp_lat = 2;
                  if (d.access) begin
                     if (wait_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL done_without_req: got completion expected a memory request first");
                     end else begin
                        exp_lat = 3 + wait_q.pop_front();
                     end
                  end
                  check("latency", 32'(cyc - d.issue + 1), 32'(exp_lat));
                  check("misalign", {31'b0, misalign}, {31'b0, d.mis});
                  if (d.chk_rdata) check("rdata", rdata, d.rdata);
               end
            end
         end
         prev_req   = dmem.dmem_req;
         prev_stall = stall;
      end
   end

   // Reference model: byte-granular view of memory, access size drives everything.
   task automatic do_access(input bit wr, input bit rd, input logic [2:0] ld,
                            input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
      bit          is_store, valid, mis, sgn;
      int          n, lane, k;
      logic [3:0]  idx;
      logic [31:0] val, msk, wd;
      req_t        rq;
      done_t       dn;

      @(posedge clk); #1;
      mem_write = wr; mem_read = rd; load = ld; store = st; addr = a; wdata = d;

      is_store = wr;
      valid    = is_store ? (st <= 2) : (ld <= 4);
      if (is_store) n = 1 << st;
      else n = (ld == 3'd2) ? 4 : ((ld == 3'd0 || ld == 3'd3) ? 1 : 2);
      sgn  = !is_store && (ld == 3'd0 || ld == 3'd1);
      lane = (int'(a[1:0]) / n) * n;
      idx  = a[5:2];
      mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis = valid && ((int'(a[1:0]) % n) != 0);
`endif
      dn.issue = cyc; dn.mis = mis; dn.chk_rdata = 1'b1; dn.rdata = 32'h0; dn.access = 1'b0;
      if (valid && !mis) begin
         dn.access = 1'b1;
         rq.addr = {a[31:2], 2'b00};
         rq.we   = is_store;
         rq.be   = 4'(((1 << n) - 1) << lane);
         msk = 32'h0; wd = 32'h0; val = 32'h0;
         for (int i = 0; i < n; i++) begin
            msk[(lane+i)*8 +: 8] = 8'hFF;
            wd[(lane+i)*8 +: 8]  = d[i*8 +: 8];
            val[i*8 +: 8]        = ref_mem[idx][(lane+i)*8 +: 8];
         end
         rq.wmask = msk; rq.wdat = wd;
         if (is_store) begin
            for (int i = 0; i < n; i++) ref_mem[idx][(lane+i)*8 +: 8] = d[i*8 +: 8];
            dn.chk_rdata = 1'b0;
         end else begin
            if (sgn && n < 4 && val[n*8-1]) val = val | ~((32'h1 << (n*8)) - 32'h1);
            dn.rdata = val;
         end
         exp_req.push_back(rq);
      end
      exp_done.push_back(dn);

      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (stall && k < 50);
      if (k >= 50) begin
         n_cmp++; n_bad++;
         $display("FAIL timeout: got stall stuck high expected completion within 50 cycles");
      end
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic preload(input int i, input logic [31:0] v);
      ref_mem[i] = v;
      sim_mem[i] = v;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      load = 3'b0; store = 2'b0; addr = 32'h0; wdata = 32'h0;
      for (int i = 0; i < 16; i++) preload(i, $urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", {31'b0, stall}, 32'h0);
      check("rst_req", {31'b0, dmem.dmem_req}, 32'h0);
      check("rst_we", {31'b0, dmem.dmem_we}, 32'h0);
      check("rst_be", {28'b0, dmem.dmem_be}, 32'h0);
      check("rst_misalign", {31'b0, misalign}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_addr", dmem.dmem_addr, 32'h0);
      check("rst_wdata", dmem.dmem_wdata, 32'h0);
      rst = 1'b0;

      forced_wait = 0;
      do_access(1'b1, 1'b0, 3'd0, 2'd2, 32'h100, 32'hDEADBEEF);
      do_access(1'b1, 1'b0, 3'd0, 2'd0, 32'h103, 32'h000000A5);
      preload(0, 32'h0080FF00);
      do_access(1'b0, 1'b1, 3'd0, 2'd0, 32'h102, 32'h0);
      do_access(1'b0, 1'b1, 3'd3, 2'd0, 32'h102, 32'h0);
      preload(0, 32'h80010000);
      forced_wait = 3;
      do_access(1'b0, 1'b1, 3'd1, 2'd0, 32'h102, 32'h0);
      forced_wait = 0;

      // Reset while the access waits on an ack that arrives with reset.
      resp_en = 1'b0; monitor_en = 1'b0;
      @(posedge clk); #1;
      mem_read = 1'b1; load = 3'd2; addr = 32'h104;
      begin
         int k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!dmem.dmem_req && k < 10);
         check("rst_test_req_seen", {31'b0, dmem.dmem_req}, 32'h1);
      end
      dmem.dmem_ack = 1'b1; rst = 1'b1; mem_read = 1'b0;
      @(negedge clk);
      check("midrst_req", {31'b0, dmem.dmem_req}, 32'h0);
      check("midrst_stall", {31'b0, stall}, 32'h0);
      check("midrst_rdata", rdata, 32'h0);
      rst = 1'b0; dmem.dmem_ack = 1'b0;
      @(negedge clk);
      resp_en = 1'b1; monitor_en = 1'b1;

      do_access(1'b0, 1'b1, 3'd2, 2'd0, 32'h101, 32'h0);
      do_access(1'b0, 1'b1, 3'd6, 2'd0, 32'h108, 32'h0);
      do_access(1'b1, 1'b1, 3'd2, 2'd3, 32'h10C, 32'h12345678);

      forced_wait = -1;
      for (int t = 0; t < 250; t++) begin
         int r;
         r = int'($urandom_range(0, 7));
         do_access(r >= 4, (r < 4) || (r == 7), 3'($urandom_range(0, 5)),
                   2'($urandom_range(0, 3)), 32'h100 + $urandom_range(0, 63), $urandom);
      end

      repeat (4) @(negedge clk);
      check("req_queue_empty", 32'(exp_req.size()), 32'h0);
      check("done_queue_empty", 32'(exp_done.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
